// File: rtl/traffic_pkg.sv
// Shared definitions for the vehicle/pedestrian crossing blocks:
// pedestrian FSM state encoding and lamp-vector bit positions.
package traffic_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2,
        FAULT = 2'd3
    } ped_state_t;

    localparam int LAMP_RED    = 0;
    localparam int LAMP_GREEN  = 1;
    localparam int LAMP_YELLOW = 2;

endpackage

// File: rtl/ped_phase_counter.sv
// Loadable down counter timing the WALK and FLASH phases.
// Load has priority over decrement; zero flags the last cycle of a phase.
module ped_phase_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle lamp outputs:
// serves latched button requests in the next red phase and locks up on bad lamp inputs.
module ped_crossing_ctrl
    import traffic_pkg::*;
#(
    parameter int WALK_CYC  = 2,
    parameter int FLASH_CYC = 2,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             green,
    input  logic             yellow,
    input  logic             ped_button,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault
);

    ped_state_t       state, state_nx;
    logic             red_d;
    logic             red_rise;
    logic             flash_ph, flash_nx;
    logic             req_nx;
    logic [2:0]       lamps;
    logic [1:0]       lamp_count;
    logic             lamp_err;
    logic             cnt_load, cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    ped_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= STOP;
            red_d       <= 1'b0;
            flash_ph    <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            red_d       <= red;
            flash_ph    <= flash_nx;
            req_pending <= req_nx;
        end
    end

    always_comb begin
        lamps              = 3'b000;
        lamps[LAMP_RED]    = red;
        lamps[LAMP_GREEN]  = green;
        lamps[LAMP_YELLOW] = yellow;
        lamp_count = {1'b0, lamps[0]} + {1'b0, lamps[1]} + {1'b0, lamps[2]};
        lamp_err   = (lamp_count != 2'd1);
        red_rise   = red & ~red_d;
    end

    always_comb begin
        state_nx     = state;
        flash_nx     = flash_ph;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state)
            STOP: begin
                if (red_rise && (req_pending || ped_button)) begin
                    state_nx     = WALK;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(WALK_CYC - 1);
                end
            end
            WALK: begin
                if (!red) begin
                    state_nx = STOP;
                end else if (cnt_zero) begin
                    state_nx     = FLASH;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(FLASH_CYC - 1);
                    flash_nx     = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            FLASH: begin
                if (!red || cnt_zero) begin
                    state_nx = STOP;
                end else begin
                    cnt_dec  = 1'b1;
                    flash_nx = ~flash_ph;
                end
            end
            FAULT: state_nx = FAULT;
            default: state_nx = FAULT;
        endcase
        // The lamp check overrides whatever the phase logic decided
        if (lamp_err) begin
            state_nx = FAULT;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
            flash_nx = flash_ph;
        end
    end

    // A press coinciding with WALK entry is served by that entry, not re-latched
    always_comb begin
        req_nx = req_pending;
        if (state == FAULT || state_nx == FAULT)
            req_nx = 1'b0;
        else if (state == STOP && state_nx == WALK)
            req_nx = 1'b0;
        else if (ped_button)
            req_nx = 1'b1;
    end

    always_comb begin
        walk      = (state == WALK) & red;
        dont_walk = 1'b1;
        countdown = '0;
        case (state)
            WALK: begin
                dont_walk = ~red;
                countdown = cnt + 1'b1;
            end
            FLASH: begin
                dont_walk = ~red | flash_ph;
                countdown = cnt + 1'b1;
            end
            default: dont_walk = 1'b1;
        endcase
        fault = (state == FAULT);
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Table-driven bench for ped_crossing_ctrl with hand-computed expectations,
// plus hand-written reset/fault sequences.
module tb_ped_crossing_ctrl;

    logic       clk;
    logic       rst_n;
    logic       red, green, yellow, ped_button;
    logic       walk, dont_walk, req_pending, fault;
    logic [2:0] countdown;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic       r, g, y, b;
        logic       w, dw;
        logic [2:0] cd;
        logic       rp, f;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs [NVEC];

    ped_crossing_ctrl #(.WALK_CYC(2), .FLASH_CYC(2), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .red         (red),
        .green       (green),
        .yellow      (yellow),
        .ped_button  (ped_button),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .countdown   (countdown),
        .req_pending (req_pending),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setRow(input int i, input logic r, g, y, b,
                          input logic w, dw, input logic [2:0] cd, input logic rp, f);
        vecs[i].r = r; vecs[i].g = g; vecs[i].y = y; vecs[i].b = b;
        vecs[i].w = w; vecs[i].dw = dw; vecs[i].cd = cd; vecs[i].rp = rp; vecs[i].f = f;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic driveLamps(input logic r, g, y, b);
        red = r; green = g; yellow = y; ped_button = b;
    endtask

    task automatic applyStimulus(input logic r, g, y, b);
        @(posedge clk);
        #1;
        driveLamps(r, g, y, b);
    endtask

    task automatic checkAll(input string tag, input logic w, dw, input logic [2:0] cd,
                            input logic rp, f);
        checkOutput({tag, ".walk"},        {7'b0, walk},        {7'b0, w});
        checkOutput({tag, ".dont_walk"},   {7'b0, dont_walk},   {7'b0, dw});
        checkOutput({tag, ".countdown"},   {5'b0, countdown},   {5'b0, cd});
        checkOutput({tag, ".req_pending"}, {7'b0, req_pending}, {7'b0, rp});
        checkOutput({tag, ".fault"},       {7'b0, fault},       {7'b0, f});
    endtask

    initial begin
        //      idx r g y b   w dw cd rp f
        // reset release with red high and button held: rise in row 0
        setRow( 0, 1,0,0,1,  0,1, 0, 0,0);
        setRow( 1, 1,0,0,0,  1,0, 2, 0,0);
        setRow( 2, 1,0,0,0,  1,0, 1, 0,0);
        setRow( 3, 1,0,0,0,  0,1, 2, 0,0);
        setRow( 4, 1,0,0,0,  0,0, 1, 0,0);
        setRow( 5, 1,0,0,0,  0,1, 0, 0,0);
        // full cycle with no request
        setRow( 6, 0,1,0,0,  0,1, 0, 0,0);
        setRow( 7, 0,0,1,0,  0,1, 0, 0,0);
        setRow( 8, 1,0,0,0,  0,1, 0, 0,0);
        setRow( 9, 1,0,0,0,  0,1, 0, 0,0);
        setRow(10, 1,0,0,0,  0,1, 0, 0,0);
        // press during green, served at the next rise
        setRow(11, 0,1,0,1,  0,1, 0, 0,0);
        setRow(12, 0,1,0,0,  0,1, 0, 1,0);
        setRow(13, 0,0,1,0,  0,1, 0, 1,0);
        setRow(14, 1,0,0,0,  0,1, 0, 1,0);
        setRow(15, 1,0,0,0,  1,0, 2, 0,0);
        setRow(16, 1,0,0,0,  1,0, 1, 0,0);
        setRow(17, 1,0,0,0,  0,1, 2, 0,0);
        // press during FLASH survives STOP
        setRow(18, 1,0,0,1,  0,0, 1, 0,0);
        setRow(19, 1,0,0,0,  0,1, 0, 1,0);
        setRow(20, 0,1,0,0,  0,1, 0, 1,0);
        setRow(21, 0,0,1,0,  0,1, 0, 1,0);
        setRow(22, 1,0,0,0,  0,1, 0, 1,0);
        setRow(23, 1,0,0,0,  1,0, 2, 0,0);
        // red lost in second WALK cycle: gated immediately, STOP next cycle
        setRow(24, 0,1,0,0,  0,1, 1, 0,0);
        setRow(25, 0,1,0,0,  0,1, 0, 0,0);
        setRow(26, 0,0,1,1,  0,1, 0, 0,0);
        setRow(27, 1,0,0,0,  0,1, 0, 1,0);
        setRow(28, 1,0,0,0,  1,0, 2, 0,0);
        // red+green mid-WALK -> FAULT, buttons ignored afterwards
        setRow(29, 1,1,0,0,  1,0, 1, 0,0);
        setRow(30, 1,0,0,1,  0,1, 0, 0,1);
        setRow(31, 0,1,0,1,  0,1, 0, 0,1);
        setRow(32, 1,0,0,1,  0,1, 0, 0,1);
        setRow(33, 1,0,0,0,  0,1, 0, 0,1);

        rst_n = 1'b0;
        driveLamps(1, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAll("reset", 0, 1, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            if (i == 0) begin
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                driveLamps(vecs[i].r, vecs[i].g, vecs[i].y, vecs[i].b);
            end else begin
                applyStimulus(vecs[i].r, vecs[i].g, vecs[i].y, vecs[i].b);
            end
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), vecs[i].w, vecs[i].dw, vecs[i].cd,
                     vecs[i].rp, vecs[i].f);
        end

        // Fault while still in reset must not stick; first cycle after release is checked
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        driveLamps(0, 0, 0, 0);
        #2;
        checkAll("rst_clears_fault", 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkAll("no_lamp_first", 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        checkAll("no_lamp_fault", 0, 1, 0, 0, 1);

        // Reset mid-WALK: immediate safe outputs, no request survives
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        driveLamps(0, 1, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        checkAll("pre_walk", 0, 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        checkAll("in_walk", 1, 0, 2, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("rst_mid_walk", 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkAll("after_rst_rise", 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        checkAll("after_rst_stop", 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
